// File: rtl/sample_framer.sv
// sample_framer: packs stereo 24-bit ADC sample pairs into 9-byte frames
// (sync, seq/overflow, left, right, XOR checksum) for a byte-wide
// valid/ready FIFO writer. A one-entry holding buffer absorbs a pair that
// arrives mid-frame. Pairs arriving while that buffer is full are counted
// as drops.
module sample_framer (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] smp_l,
  input  logic [23:0] smp_r,
  input  logic        smp_strobe,
  input  logic        adc_ovfl_,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  drop_cnt,
  output logic        busy
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [3:0] LAST_IDX  = 4'd8;

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
    logic        ovf;   // active-high overflow, already inverted
  } pair_t;

  state_t      state_q;
  pair_t       frame_q;
  pair_t       hold_q;
  logic [6:0]  frame_seq_q;
  logic [6:0]  seq_q;
  logic        hold_full_q;
  logic [3:0]  idx_q;
  logic [7:0]  out_data_q;
  logic        out_valid_q;
  logic [7:0]  drop_cnt_q;

  pair_t       in_pair;
  pair_t       load_src_d;
  logic        load_d;
  logic        accept;
  logic        last_accept;
  logic [3:0]  next_idx_d;
  logic [7:0]  next_byte_d;
  logic [7:0]  frame_bytes [9];

  assign in_pair     = '{l: smp_l, r: smp_r, ovf: ~adc_ovfl_};
  assign accept      = out_valid_q & out_ready;
  assign last_accept = accept & (idx_q == LAST_IDX);
  assign next_idx_d  = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;

  // Frame bytes built from the stored frame, so the checksum never sees live inputs.
  always_comb begin
    frame_bytes[0] = SYNC_BYTE;
    frame_bytes[1] = {frame_seq_q, frame_q.ovf};
    frame_bytes[2] = frame_q.l[23:16];
    frame_bytes[3] = frame_q.l[15:8];
    frame_bytes[4] = frame_q.l[7:0];
    frame_bytes[5] = frame_q.r[23:16];
    frame_bytes[6] = frame_q.r[15:8];
    frame_bytes[7] = frame_q.r[7:0];
    frame_bytes[8] = frame_bytes[0] ^ frame_bytes[1] ^ frame_bytes[2] ^ frame_bytes[3]
                   ^ frame_bytes[4] ^ frame_bytes[5] ^ frame_bytes[6] ^ frame_bytes[7];
    next_byte_d    = frame_bytes[next_idx_d];
  end

  // Decide whether a new frame starts next cycle, and from which source.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    load_d     = 1'b0;
    load_src_d = in_pair;
    if (!rst) begin
      unique case (state_q)
        IDLE: load_d = smp_strobe;
        SEND: begin
          if (last_accept) begin
            load_d     = hold_full_q | smp_strobe;
            load_src_d = hold_full_q ? hold_q : in_pair;
          end
        end
        default: load_d = 1'b0;
      endcase
    end
  end

  // Sample payload storage: frame register and holding buffer contents.
  // NOTE: payload registers carry no reset; their valid flags (state_q, hold_full_q) do.
  always_ff @(posedge clk) begin
    if (load_d) begin
      frame_q <= load_src_d;
    end
    if (!rst && smp_strobe && state_q == SEND
        && ((!hold_full_q && !last_accept) || (hold_full_q && last_accept))) begin
      hold_q <= in_pair;
    end
  end

  // Control FSM: state, byte index, sequence, holding flag, drop counter and outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so reads see pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      frame_seq_q <= 7'd0;
      seq_q       <= 7'd0;
      hold_full_q <= 1'b0;
      idx_q       <= 4'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      drop_cnt_q  <= 8'h00;
    end else if (load_d) begin
      // Start a new frame; B0 is presented on the following cycle.
      state_q     <= SEND;
      frame_seq_q <= seq_q;
      seq_q       <= seq_q + 7'd1;
      idx_q       <= 4'd0;
      out_data_q  <= SYNC_BYTE;
      out_valid_q <= 1'b1;
      // Draining the holding buffer: refilled only if a strobe lands this cycle.
      if (state_q == SEND && hold_full_q && !smp_strobe) begin
        hold_full_q <= 1'b0;
      end
    end else if (state_q == SEND) begin
      if (last_accept) begin
        // Frame finished with nothing pending.
        state_q     <= IDLE;
        idx_q       <= 4'd0;
        out_data_q  <= 8'h00;
        out_valid_q <= 1'b0;
      end else begin
        if (accept) begin
          idx_q      <= next_idx_d;
          out_data_q <= next_byte_d;
        end
        if (smp_strobe) begin
          if (!hold_full_q) begin
            hold_full_q <= 1'b1;
          end else if (drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
          end
        end
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (state_q == SEND) | hold_full_q;

endmodule

// File: tb/tb_sample_framer.sv
// Testbench for sample_framer: a scoreboard queue is filled with expected
// frame bytes as sample pairs are strobed in, and a negedge monitor pops
// and compares every byte the DUT hands over, also checking stall stability.
module tb_sample_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] smp_l;
  logic [23:0] smp_r;
  logic        smp_strobe;
  logic        adc_ovfl_;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  drop_cnt;
  logic        busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q [$];
  logic [6:0] m_seq;
  int         m_drop;
  logic       stall_pend;
  logic [7:0] stall_data;

  always #5 clk = ~clk;

  sample_framer dut (
    .clk        (clk),
    .rst        (rst),
    .smp_l      (smp_l),
    .smp_r      (smp_r),
    .smp_strobe (smp_strobe),
    .adc_ovfl_  (adc_ovfl_),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame for a pair under the bench's own sequence counter.
  task automatic push_frame(input logic [23:0] l, input logic [23:0] r, input logic ovfl_n);
    logic [7:0] b [9];
    b[0] = 8'hA5;
    b[1] = {m_seq, ~ovfl_n};
    b[2] = l[23:16]; b[3] = l[15:8]; b[4] = l[7:0];
    b[5] = r[23:16]; b[6] = r[15:8]; b[7] = r[7:0];
    b[8] = 8'h00;
    for (int i = 0; i < 8; i++) b[8] = b[8] ^ b[i];
    for (int i = 0; i < 9; i++) exp_q.push_back(b[i]);
    m_seq = m_seq + 7'd1;
  endtask

  // mode 0: model pushes the frame; 1: pair expected dropped; 2: caller pushed already.
  task automatic strobe(input logic [23:0] l, input logic [23:0] r, input logic ovfl_n,
                        input int mode);
    smp_l = l; smp_r = r; adc_ovfl_ = ovfl_n; smp_strobe = 1'b1;
    tick();
    smp_strobe = 1'b0;
    if (mode == 0) push_frame(l, r, ovfl_n);
    else if (mode == 1) m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
  endtask

  task automatic push_lit(input logic [71:0] bytes);
    for (int i = 8; i >= 0; i--) exp_q.push_back(bytes[i*8 +: 8]);
    m_seq = m_seq + 7'd1;
  endtask

  task automatic drain(input string tag, output int cycles);
    cycles = 0;
    while (out_valid && cycles < 200) begin
      tick();
      cycles++;
    end
    check({tag, "_bound"}, 32'(cycles < 200), 32'd1);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Byte monitor: compares every accepted byte and checks stalls hold steady.
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(stall_data));
      end
      if (out_valid && out_ready) begin
        check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("byte", 32'(out_data), 32'(exp_q.pop_front()));
        stall_pend = 1'b0;
      end else if (out_valid) begin
        stall_pend = 1'b1;
        stall_data = out_data;
      end else begin
        stall_pend = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int c;
    rst = 1'b1; smp_strobe = 1'b0; smp_l = '0; smp_r = '0; adc_ovfl_ = 1'b1;
    out_ready = 1'b1; m_seq = 7'd0; m_drop = 0; stall_pend = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Basic frame, no overflow, seq 0.
    push_lit(72'hA5_00_12_34_56_AB_CD_EF_5C);
    strobe(24'h123456, 24'hABCDEF, 1'b1, 2);
    check("t1_first_valid", 32'(out_valid), 32'd1);
    check("t1_first_data", 32'(out_data), 32'hA5);
    check("t1_busy", 32'(busy), 32'd1);
    drain("t1", c);
    check("t1_len", 32'(c), 32'd9);

    // Overflow asserted, seq 1.
    push_lit(72'hA5_03_12_34_56_AB_CD_EF_5F);
    strobe(24'h123456, 24'hABCDEF, 1'b0, 2);
    drain("t2", c);
    check("t2_len", 32'(c), 32'd9);

    // Backpressure pattern 1,0,0 repeating.
    strobe(24'h123456, 24'hABCDEF, 1'b1, 0);
    c = 0;
    while (out_valid && c < 100) begin
      out_ready = (c % 3 == 0);
      tick();
      c++;
    end
    check("t3_len", 32'(c), 32'd25);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;

    // Frame + holding + drop while stalled, then back-to-back release.
    out_ready = 1'b0;
    strobe(24'h000001, 24'hFFFFFF, 1'b1, 0);
    strobe(24'h800000, 24'h7FFFFF, 1'b0, 0);
    strobe(24'h555555, 24'hAAAAAA, 1'b1, 1);
    check("t4_drop", 32'(drop_cnt), 32'(m_drop));
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_stall_b0", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    drain("t4", c);
    check("t4_len", 32'(c), 32'd18);

    // Strobe on B8 acceptance with holding empty: loads directly, no gap.
    strobe(24'h0F0F0F, 24'hF0F0F0, 1'b1, 0);
    for (int i = 0; i < 8; i++) tick();
    strobe(24'h13579B, 24'h2468AC, 1'b0, 0);
    drain("t5a", c);
    check("t5a_len", 32'(9 + c), 32'd18);

    // Strobe on B8 acceptance with holding full: no drop, three contiguous frames.
    strobe(24'h111111, 24'h222222, 1'b1, 0);
    strobe(24'h333333, 24'h444444, 1'b0, 0);
    for (int i = 0; i < 7; i++) tick();
    strobe(24'h555555, 24'h666666, 1'b1, 0);
    drain("t5b", c);
    check("t5b_len", 32'(9 + c), 32'd27);
    check("t5b_drop", 32'(drop_cnt), 32'(m_drop));

    // Saturating drop counter.
    out_ready = 1'b0;
    strobe(24'hABCDEF, 24'h123456, 1'b1, 0);
    strobe(24'hFEDCBA, 24'h654321, 1'b1, 0);
    for (int i = 0; i < 300; i++) strobe(24'(i), 24'(i * 3), 1'b0, 1);
    check("t6_drop_sat", 32'(drop_cnt), 32'hFF);
    out_ready = 1'b1;
    drain("t6", c);
    check("t6_len", 32'(c), 32'd18);

    // Reset mid-frame at byte index 4; strobe during reset is ignored.
    strobe(24'hDEAD00, 24'h00BEEF, 1'b1, 0);
    for (int i = 0; i < 4; i++) tick();
    check("t7_idx4_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; smp_strobe = 1'b1;
    tick();
    check("t7_rst_valid", 32'(out_valid), 32'd0);
    check("t7_rst_data", 32'(out_data), 32'h00);
    check("t7_rst_drop", 32'(drop_cnt), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    m_seq = 7'd0; m_drop = 0;
    smp_strobe = 1'b0; rst = 1'b0;
    tick();
    check("t7_post_idle", 32'(out_valid), 32'd0);
    strobe(24'h123456, 24'hABCDEF, 1'b1, 0);
    check("t7_b0", 32'(out_data), 32'hA5);
    tick();
    check("t7_b1", 32'(out_data), 32'h00);
    drain("t7", c);
    check("t7_len", 32'(c + 1), 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
